// File: rtl/energy_sample_uart_tx.sv
// rtl/energy_sample_uart_tx.sv - sample FIFO feeding a framed 8N1 UART packet transmitter
// Packet = HEADER, PKT_LEN samples, 8-bit sum of the samples; bytes sent back-to-back.
module energy_sample_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PKT_LEN      = 4,
    parameter int unsigned DEPTH        = 8,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    output logic       sample_ready,
    output logic       txd,
    output logic       busy,
    output logic       overflow
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam int unsigned SW = $clog2(PKT_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_CHK} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    byte_q, byte_d, sum_q, sum_d;
    logic [SW-1:0] sent_q, sent_d;
    logic          txd_q, txd_d, busy_q, busy_d, ovf_q, ovf_d;
    logic          push, pop, bit_end, frame_end;
    logic [7:0]    head_data;
    logic [9:0]    frame_d;

    assign sample_ready = (count_q != CW'(DEPTH));
    assign push         = sample_valid && sample_ready && ena;
    assign head_data    = mem[head_q];
    assign txd          = txd_q;
    assign busy         = busy_q;
    assign overflow     = ovf_q;

    always_ff @(posedge clk) begin
        if (push) mem[tail_q] <= sample_in;
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        sum_d     = sum_q;
        sent_d    = sent_q;
        pop       = 1'b0;
        bit_end   = (tick_q == TW'(CLKS_PER_BIT - 1));
        frame_end = bit_end && (bit_q == 4'd9);

        if (state_q == S_IDLE) begin
            if (ena && count_q >= CW'(PKT_LEN)) begin
                state_d = S_HDR;
                byte_d  = HEADER;
                sum_d   = '0;
                sent_d  = '0;
                tick_d  = '0;
                bit_d   = '0;
            end
        end else if (frame_end) begin
            // The next byte's start bit follows the stop bit with no gap.
            tick_d = '0;
            bit_d  = '0;
            if (state_q == S_CHK) begin
                state_d = S_IDLE;
            end else if (state_q == S_HDR || sent_q < SW'(PKT_LEN)) begin
                pop     = 1'b1;
                byte_d  = head_data;
                sum_d   = sum_q + head_data;
                sent_d  = sent_q + SW'(1);
                state_d = S_DATA;
            end else begin
                byte_d  = sum_q;
                state_d = S_CHK;
            end
        end else if (bit_end) begin
            tick_d = '0;
            bit_d  = bit_q + 4'd1;
        end else begin
            tick_d = tick_q + TW'(1);
        end

        frame_d = {1'b1, byte_d, 1'b0};
        txd_d   = (state_d == S_IDLE) ? 1'b1 : frame_d[bit_d];
        busy_d  = (state_d != S_IDLE);
        ovf_d   = ovf_q | (sample_valid && (!ena || !sample_ready));

        head_d  = pop  ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            sum_q   <= '0;
            sent_q  <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            sum_q   <= sum_d;
            sent_q  <= sent_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_energy_sample_uart_tx.sv
// tb/tb_energy_sample_uart_tx.sv - directed and randomized checks of energy_sample_uart_tx against a packet-level model
module tb_energy_sample_uart_tx;
    localparam int         CPB     = 4;
    localparam int         PKT_LEN = 4;
    localparam int         DEPTH   = 8;
    localparam logic [7:0] HEADER  = 8'hA5;
    localparam int         BYTE_T  = 10 * CPB;
    localparam int         PKT_T   = (PKT_LEN + 2) * BYTE_T;

    logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0, sample_valid = 1'b0;
    logic [7:0] sample_in = 8'h00;
    logic       sample_ready, txd, busy, overflow;
    int         checks = 0, errors = 0;

    energy_sample_uart_tx #(.CLKS_PER_BIT(CPB), .PKT_LEN(PKT_LEN), .DEPTH(DEPTH), .HEADER(HEADER)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .txd(txd), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: FIFO as a queue, a packet as a byte list indexed by time since the start bit.
    logic [7:0] mq[$];
    logic [7:0] m_bytes [PKT_LEN+2];
    logic [7:0] m_sum = 8'h00;
    bit         m_ovf = 1'b0, m_act = 1'b0, m_push = 1'b0;
    int         m_t = 0, m_sz = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_ovf = 1'b0;
            m_act = 1'b0;
            m_t   = 0;
        end else begin
            m_sz   = mq.size();
            m_push = sample_valid && ena && (m_sz < DEPTH);
            if (sample_valid && (!ena || m_sz == DEPTH)) m_ovf = 1'b1;
            if (m_act) begin
                m_t++;
                if (m_t % BYTE_T == 0 && m_t / BYTE_T <= PKT_LEN) void'(mq.pop_front());
                if (m_t == PKT_T) m_act = 1'b0;
            end else if (ena && m_sz >= PKT_LEN) begin
                m_act      = 1'b1;
                m_t        = 0;
                m_sum      = 8'h00;
                m_bytes[0] = HEADER;
                for (int i = 0; i < PKT_LEN; i++) begin
                    m_bytes[i+1] = mq[i];
                    m_sum        = m_sum + mq[i];
                end
                m_bytes[PKT_LEN+1] = m_sum;
            end
            if (m_push) mq.push_back(sample_in);
        end
    end

    logic [7:0] c_byte;
    int         c_k;
    logic       c_txd;

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (m_act) begin
                c_byte = m_bytes[m_t / BYTE_T];
                c_k    = (m_t % BYTE_T) / CPB;
                c_txd  = (c_k == 0) ? 1'b0 : (c_k == 9) ? 1'b1 : c_byte[c_k-1];
            end else begin
                c_txd = 1'b1;
            end
            chk("txd", 32'(txd), 32'(c_txd));
            chk("busy", 32'(busy), 32'(m_act));
            chk("sample_ready", 32'(sample_ready), 32'(mq.size() != DEPTH));
            chk("overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_seq(input logic [7:0] d [9], input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample_in    = d[i];
        end
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    // Decodes one packet off txd, sampling each data bit mid-bit; returns at the first idle cycle.
    task automatic recv_packet(output logic [7:0] b [PKT_LEN+2], output int busy_cyc, output int wait_cyc);
        int j;
        bit ok;
        wait_cyc = 0;
        busy_cyc = 0;
        for (int i = 0; i < PKT_LEN + 2; i++) b[i] = 8'h00;
        do begin
            @(negedge clk);
            wait_cyc++;
        end while (txd !== 1'b0 && wait_cyc < 4 * PKT_T);
        ok = (txd === 1'b0);
        chk("recv_start_seen", 32'(ok), 32'd1);
        if (ok) begin
            j        = 0;
            busy_cyc = (busy === 1'b1) ? 1 : 0;
            for (int bi = 0; bi < PKT_LEN + 2; bi++) begin
                for (int k = 1; k <= 8; k++) begin
                    while (j < (bi * 10 + k) * CPB + CPB / 2) begin
                        @(negedge clk);
                        j++;
                        if (busy === 1'b1) busy_cyc++;
                    end
                    b[bi][k-1] = txd;
                end
            end
            while (busy === 1'b1 && j < 2 * PKT_T) begin
                @(negedge clk);
                j++;
                if (busy === 1'b1) busy_cyc++;
            end
        end
    endtask

    task automatic chk_pkt(input string name, input logic [7:0] got [PKT_LEN+2], input logic [7:0] exp [PKT_LEN+2]);
        for (int i = 0; i < PKT_LEN + 2; i++)
            chk($sformatf("%s_byte%0d", name, i), 32'(got[i]), 32'(exp[i]));
    endtask

    logic [7:0] d [9];
    logic [7:0] d2 [9];
    logic [7:0] rx [PKT_LEN+2];
    logic [7:0] rx2 [PKT_LEN+2];
    logic [7:0] e [PKT_LEN+2];
    int         bc, wc, bc2, wc2;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 900000");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        chk("reset_txd", 32'(txd), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_ready", 32'(sample_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;

        d = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        push_seq(d, 4);
        recv_packet(rx, bc, wc);
        e = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0};
        chk_pkt("basic", rx, e);
        chk("basic_busy_cycles", 32'(bc), 32'd240);
        chk("basic_idle_txd", 32'(txd), 32'd1);

        d = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        push_seq(d, 4);
        recv_packet(rx, bc, wc);
        e = '{8'hA5, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h01};
        chk_pkt("wrap", rx, e);

        do_reset();
        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    @(negedge clk);
                    if (i == 8) chk("full_ready_low", 32'(sample_ready), 32'd0);
                    sample_valid = 1'b1;
                    sample_in    = d[i];
                end
                @(negedge clk);
                sample_valid = 1'b0;
                chk("full_overflow_set", 32'(overflow), 32'd1);
            end
            begin
                recv_packet(rx, bc, wc);
                recv_packet(rx2, bc2, wc2);
            end
        join
        e = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
        chk_pkt("full_pkt1", rx, e);
        e = '{8'hA5, 8'h55, 8'h66, 8'h77, 8'h88, 8'hBA};
        chk_pkt("full_pkt2", rx2, e);
        chk("full_gap", 32'(wc2), 32'd1);
        chk("full_overflow_sticky", 32'(overflow), 32'd1);

        do_reset();
        ena = 1'b0;
        d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        push_seq(d, 4);
        repeat (40) @(negedge clk);
        chk("gate_busy", 32'(busy), 32'd0);
        chk("gate_txd", 32'(txd), 32'd1);
        chk("gate_overflow", 32'(overflow), 32'd1);
        chk("gate_ready", 32'(sample_ready), 32'd1);
        ena = 1'b1;
        push_seq(d, 4);
        recv_packet(rx, bc, wc);
        e = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        chk_pkt("gate_pkt", rx, e);

        d  = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        d2 = '{8'hF0, 8'h0F, 8'h80, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        push_seq(d, 4);
        fork
            recv_packet(rx, bc, wc);
            begin
                repeat (60) @(negedge clk);
                push_seq(d2, 4);
            end
        join
        recv_packet(rx2, bc2, wc2);
        e = '{8'hA5, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h0A};
        chk_pkt("conc_pkt1", rx, e);
        e = '{8'hA5, 8'hF0, 8'h0F, 8'h80, 8'h7F, 8'hFE};
        chk_pkt("conc_pkt2", rx2, e);
        chk("conc_gap", 32'(wc2), 32'd1);
        chk("conc_busy_cycles", 32'(bc2), 32'd240);

        d = '{8'h33, 8'h33, 8'h33, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        push_seq(d, 4);
        wc = 0;
        while (txd !== 1'b0 && wc < 100) begin
            @(negedge clk);
            wc++;
        end
        chk("mid_start_seen", 32'(txd), 32'd0);
        repeat (2 * BYTE_T + 10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_txd", 32'(txd), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        chk("mid_rst_ready", 32'(sample_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("mid_after_busy", 32'(busy), 32'd0);
        chk("mid_after_txd", 32'(txd), 32'd1);
        d = '{8'h5A, 8'h5B, 8'h5C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        push_seq(d, 3);
        repeat (60) @(negedge clk);
        chk("mid_three_busy", 32'(busy), 32'd0);
        d = '{8'h5D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        push_seq(d, 1);
        recv_packet(rx, bc, wc);
        e = '{8'hA5, 8'h5A, 8'h5B, 8'h5C, 8'h5D, 8'h6E};
        chk_pkt("mid_pkt", rx, e);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (c == 2000 || c == 3100) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            sample_valid = (c < 2000) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 69) == 0);
            sample_in    = 8'($urandom);
            ena          = ($urandom_range(0, 19) != 0);
        end
        @(negedge clk);
        sample_valid = 1'b0;
        ena          = 1'b1;
        repeat (2 * PKT_T) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
